// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word size, default base address and the address-offset helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int          WORD_BYTES        = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Byte offset of an address from the window base; addresses below the
    // base wrap to a huge unsigned offset and therefore fall out of range.
    function automatic logic [31:0] wordOffset(input logic [31:0] addr,
                                               input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The read register only changes on a read access, so it holds the last
// loaded word until the next load. Contents are never reset.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    // One access per enabled edge: either write the word or register it out.
    always_ff @(posedge clk) begin
        if (ce_i) begin
            if (we_i) begin
                mem[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the CPU load/store port. Accepts one
// word request at a time, waits WAIT_CYCLES, commits the access to the RAM
// on entry to RESP and holds the response until the CPU takes it.
import dmem_pkg::*;

module dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0]  WAIT_START = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [32:0] WIN_BYTES  = 33'(WORD_BYTES) << DEPTH_LOG2;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        reqWe_q;
    logic [31:0] reqAddr_q;
    logic [31:0] reqWdata_q;

    logic        loadOk_q, loadOk_d;
    logic        err_q, err_d;

    logic        accept;
    logic        commit;
    logic        cWe;
    logic [31:0] cAddr;
    logic [31:0] cWdata;
    logic [31:0] cOffset;
    logic        cErr;

    logic        ramCe;
    logic [31:0] ramRdata;

    // Next state, wait counter and selection of the access being committed.
    // With zero wait states the commit happens on the accept edge, so the
    // access comes straight from the request inputs instead of the latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        cWe     = reqWe_q;
        cAddr   = reqAddr_q;
        cWdata  = reqWdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        cWe     = req_we;
                        cAddr   = req_addr;
                        cWdata  = req_wdata;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_START;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address decode of the committing access and response flag updates.
    always_comb begin
        cOffset  = wordOffset(cAddr, BASE_ADDR);
        cErr     = (cAddr[1:0] != 2'b00) || ({1'b0, cOffset} >= WIN_BYTES);
        ramCe    = commit && !cErr;
        err_d    = commit ? cErr : err_q;
        loadOk_d = commit ? (!cWe && !cErr) : loadOk_q;
    end

    // FSM state, wait counter and response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            loadOk_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loadOk_q <= loadOk_d;
            err_q    <= err_d;
        end
    end

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Capture the request on the accept edge for use at the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqWe_q    <= 1'b0;
            reqAddr_q  <= 32'd0;
            reqWdata_q <= 32'd0;
        end else if (accept) begin
            reqWe_q    <= req_we;
            reqAddr_q  <= req_addr;
            reqWdata_q <= req_wdata;
        end
    end

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .ce_i    (ramCe),
        .we_i    (cWe),
        .idx_i   (cOffset[DEPTH_LOG2+1:2]),
        .wdata_i (cWdata),
        .rdata_o (ramRdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = loadOk_q ? ramRdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with zero wait states, checked with immediate assertions.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValidA, reqValidB;
    logic        reqWe;
    logic [31:0] reqAddr, reqWdata;
    logic        respReadyA, respReadyB;
    logic        reqReadyA, reqReadyB;
    logic        respValidA, respValidB;
    logic [31:0] respRdataA, respRdataB;
    logic        respErrA, respErrB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_LOG2(10), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(2)
    ) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValidA), .resp_ready(respReadyA),
        .resp_rdata(respRdataA), .resp_err(respErrA)
    );

    dmem_responder #(
        .DEPTH_LOG2(10), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(0)
    ) dutB (
        .clk(clk), .rst(rst),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValidB), .resp_ready(respReadyB),
        .resp_rdata(respRdataB), .resp_err(respErrB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request to instance A (sel=0) or B (sel=1) for one edge;
    // returns at the falling edge following the accept edge.
    task automatic applyStimulus(input bit sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag);
        @(negedge clk);
        checkOutput({tag, "_req_ready"}, sel ? reqReadyB : reqReadyA, 32'd1);
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        if (sel) reqValidB = 1'b1; else reqValidA = 1'b1;
        @(negedge clk);
        reqValidA = 1'b0;
        reqValidB = 1'b0;
    endtask

    // Count cycles from the accept edge until resp_valid, bounded.
    task automatic waitResp(input bit sel, input int expLat, input string tag);
        int n = 1;
        while (!(sel ? respValidB : respValidA) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
    endtask

    // Take the response and check the responder is back in IDLE.
    task automatic finishResp(input bit sel, input string tag);
        if (sel) respReadyB = 1'b1; else respReadyA = 1'b1;
        @(negedge clk);
        respReadyA = 1'b0;
        respReadyB = 1'b0;
        checkOutput({tag, "_valid_drop"}, sel ? respValidB : respValidA, 32'd0);
        checkOutput({tag, "_idle_ready"}, sel ? reqReadyB : reqReadyA, 32'd1);
    endtask

    task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int expLat,
                          input logic [31:0] expData, input logic expErr, input string tag);
        applyStimulus(sel, we, addr, wdata, tag);
        waitResp(sel, expLat, tag);
        checkOutput({tag, "_rdata"}, sel ? respRdataB : respRdataA, expData);
        checkOutput({tag, "_err"}, sel ? respErrB : respErrA, 32'(expErr));
        finishResp(sel, tag);
    endtask

    // Directed sequence: reset, store/load, errors, reset mid-access,
    // backpressure, then the zero-wait instance.
    initial begin
        rst = 1'b1;
        reqValidA = 1'b0; reqValidB = 1'b0; reqWe = 1'b0;
        reqAddr = 32'd0; reqWdata = 32'd0;
        respReadyA = 1'b0; respReadyB = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstA_ready", reqReadyA, 32'd1);
        checkOutput("rstA_valid", respValidA, 32'd0);
        checkOutput("rstA_err", respErrA, 32'd0);
        checkOutput("rstA_rdata", respRdataA, 32'd0);
        checkOutput("rstB_ready", reqReadyB, 32'd1);
        rst = 1'b0;

        access(0, 1'b1, 32'h1001_0004, 32'h1111_2222, 3, 32'd0, 1'b0, "sw_04");
        access(0, 1'b1, 32'h1001_0010, 32'hA5A5_A5A5, 3, 32'd0, 1'b0, "sw_10");
        access(0, 1'b1, 32'h1001_0FFC, 32'h0BAD_F00D, 3, 32'd0, 1'b0, "sw_last");
        access(0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 3, 32'd0, 1'b0, "sw_08");
        access(0, 1'b0, 32'h1001_0008, 32'd0, 3, 32'hDEAD_BEEF, 1'b0, "lw_08");
        access(0, 1'b1, 32'h1001_0006, 32'h0000_0001, 3, 32'd0, 1'b1, "sw_misal");
        access(0, 1'b0, 32'h1001_0004, 32'd0, 3, 32'h1111_2222, 1'b0, "lw_04");
        access(0, 1'b0, 32'h1001_0FFC, 32'd0, 3, 32'h0BAD_F00D, 1'b0, "lw_last");
        access(0, 1'b0, 32'h1000_FFFC, 32'd0, 3, 32'd0, 1'b1, "lw_below");
        access(0, 1'b0, 32'h1001_1000, 32'd0, 3, 32'd0, 1'b1, "lw_range");

        // Reset while a store sits in WAIT; resp_err is still 1 from above.
        applyStimulus(0, 1'b1, 32'h1001_0010, 32'h1234_5678, "sw_abort");
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", reqReadyA, 32'd1);
        checkOutput("midrst_valid", respValidA, 32'd0);
        checkOutput("midrst_err", respErrA, 32'd0);
        checkOutput("midrst_rdata", respRdataA, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b0, 32'h1001_0010, 32'd0, 3, 32'hA5A5_A5A5, 1'b0, "lw_after_rst");

        // Backpressure with a competing request held on the inputs.
        applyStimulus(0, 1'b0, 32'h1001_0008, 32'd0, "lw_bp");
        waitResp(0, 3, "lw_bp");
        reqValidA = 1'b1;
        reqWe     = 1'b1;
        reqAddr   = 32'h1001_0004;
        reqWdata  = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", respValidA, 32'd1);
            checkOutput("bp_rdata", respRdataA, 32'hDEAD_BEEF);
            checkOutput("bp_ready", reqReadyA, 32'd0);
        end
        reqValidA = 1'b0;
        finishResp(0, "lw_bp");
        access(0, 1'b0, 32'h1001_0004, 32'd0, 3, 32'h1111_2222, 1'b0, "lw_04_again");

        // Zero-wait instance: back-to-back store then load.
        access(1, 1'b1, 32'h1001_0000, 32'hCAFE_F00D, 1, 32'd0, 1'b0, "b_sw_00");
        access(1, 1'b0, 32'h1001_0000, 32'd0, 1, 32'hCAFE_F00D, 1'b0, "b_lw_00");
        access(1, 1'b0, 32'h1001_0002, 32'd0, 1, 32'd0, 1'b1, "b_lw_misal");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
